// File: rtl/freq_sweep_ctrl.sv
// Stepped-frequency clock divider: sweeps the tap select of a 12-bit counter up or down,
// switching taps only at counter wrap. Optional macro FSWEEP_LOOP_EN repeats the sweep until abort.
module freq_sweep_ctrl (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic [3:0] dwell,
  input  logic       abort,
  output logic       clk_out,
  output logic [1:0] sel_cur,
  output logic       tick,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [11:0] cnt;
  logic [1:0]  sel_nxt;
  logic        mode_q, mode_nxt;
  logic [3:0]  dwell_q, dwell_nxt;
  logic [3:0]  ecount, ecount_nxt;
  logic        clk_out_d;
  logic        wrap;
  logic [3:0]  dwell_eff;
  logic        met_reg, met_now, cnt_tick;
  logic        last_step;
  logic [1:0]  first_sel, step_sel;
`ifdef FSWEEP_LOOP_EN
  logic        done_q, done_pulse;
`endif

  always_comb begin
    case (sel_cur)
      2'b00:   clk_out = cnt[11];
      2'b01:   clk_out = cnt[10];
      2'b10:   clk_out = cnt[9];
      default: clk_out = cnt[8];
    endcase
  end

  assign tick      = clk_out & ~clk_out_d;
  assign wrap      = (cnt == 12'hFFF);
  assign dwell_eff = (dwell_q == 4'd0) ? 4'd1 : dwell_q;
  assign met_reg   = (ecount >= dwell_eff);
  assign cnt_tick  = tick & ~met_reg;
  // Include the tick being counted this cycle so the last step finishes one cycle after it.
  assign met_now   = met_reg | (cnt_tick & ((ecount + 4'd1) == dwell_eff));
  assign last_step = mode_q ? (sel_cur == 2'b00) : (sel_cur == 2'b11);
  assign first_sel = {2{mode_q}};
  assign step_sel  = mode_q ? (sel_cur - 2'd1) : (sel_cur + 2'd1);
  assign busy      = (state == ARM) || (state == RUN);

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel_cur;
    mode_nxt   = mode_q;
    dwell_nxt  = dwell_q;
    ecount_nxt = ecount;
`ifdef FSWEEP_LOOP_EN
    done_pulse = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          mode_nxt   = mode;
          dwell_nxt  = dwell;
          ecount_nxt = '0;
          state_nxt  = ARM;
        end
      end
      ARM: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (wrap) begin
          sel_nxt    = first_sel;
          ecount_nxt = '0;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          if (cnt_tick) ecount_nxt = ecount + 4'd1;
`ifdef FSWEEP_LOOP_EN
          done_pulse = last_step & met_now & ~met_reg;
          if (met_reg && wrap) begin
            sel_nxt    = last_step ? first_sel : step_sel;
            ecount_nxt = '0;
          end
`else
          if (met_now && last_step) begin
            state_nxt = DONE;
          end else if (met_reg && wrap) begin
            sel_nxt    = step_sel;
            ecount_nxt = '0;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FSWEEP_LOOP_EN
  assign done = done_q;
`else
  assign done = (state == DONE);
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sel_cur   <= '0;
      state     <= IDLE;
      mode_q    <= 1'b0;
      dwell_q   <= '0;
      ecount    <= '0;
      clk_out_d <= 1'b0;
`ifdef FSWEEP_LOOP_EN
      done_q    <= 1'b0;
`endif
    end else begin
      cnt       <= cnt + 12'd1;
      sel_cur   <= sel_nxt;
      state     <= state_nxt;
      mode_q    <= mode_nxt;
      dwell_q   <= dwell_nxt;
      ecount    <= ecount_nxt;
      clk_out_d <= clk_out;
`ifdef FSWEEP_LOOP_EN
      done_q    <= done_pulse;
`endif
    end
  end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Scoreboard bench for freq_sweep_ctrl: expected sel/busy/done transitions are queued with
// their cycle stamps (cycles since reset release) and matched by a negedge monitor.
module tb_freq_sweep_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b1;
  logic       start  = 1'b0;
  logic       mode   = 1'b0;
  logic [3:0] dwell  = 4'd0;
  logic       abort  = 1'b0;
  logic       clk_out, tick, busy, done;
  logic [1:0] sel_cur;

  freq_sweep_ctrl dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .dwell   (dwell),
    .abort   (abort),
    .clk_out (clk_out),
    .sel_cur (sel_cur),
    .tick    (tick),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk_in = ~clk_in;

  // Time base: cycles since reset release (equals the DUT counter modulo 4096).
  int unsigned cyc;
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int          kind;  // 0 sel_cur, 1 busy, 2 done
    int          val;
    int unsigned at;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic expect_ev(input int kind, input int val, input int unsigned at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cyc 0x%0h)", name, act, req, cyc);
    end
  endtask

  task automatic got_ev(input int kind, input int val);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d val %0d at cyc 0x%0h, required none",
               kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.at != cyc) begin
        n_fail++;
        $display("FAIL event_match: got kind %0d val %0d at cyc 0x%0h, required kind %0d val %0d at cyc 0x%0h",
                 kind, val, cyc, e.kind, e.val, e.at);
      end
    end
  endtask

  task automatic monitor_loop();
    logic [1:0]  p_sel;
    logic        p_busy, p_done, lvl, run_ok;
    int unsigned run;
    p_sel = '0; p_busy = 1'b0; p_done = 1'b0; lvl = 1'b0; run_ok = 1'b0; run = 0;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        p_sel = '0; p_busy = 1'b0; p_done = 1'b0;
        lvl = 1'b0; run_ok = 1'b0; run = 0;
      end else begin
        if (sel_cur != p_sel) begin
          got_ev(0, int'(sel_cur));
          chk("sel_switch_clk_out_low", int'(clk_out), 0);
          chk("sel_switch_at_wrap", int'(cyc % 4096), 0);
          p_sel = sel_cur;
        end
        if (busy != p_busy) begin
          got_ev(1, int'(busy));
          p_busy = busy;
        end
        if (done != p_done) begin
          got_ev(2, int'(done));
          p_done = done;
        end
        if (clk_out == lvl) begin
          run++;
        end else begin
          if (run_ok) begin
            n_tests++;
            if (run < 256) begin
              n_fail++;
              $display("FAIL clk_out_min_width: got %0d cycles, required >= 256 (cyc 0x%0h)", run, cyc);
            end
          end
          lvl = clk_out; run = 1; run_ok = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk_in);
  endtask

  task automatic pulse_start(input logic m, input logic [3:0] d);
    start = 1'b1; mode = m; dwell = d;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk_in);
    #2 rst_n = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    start = 1'b0; abort = 1'b0;
    rst_n = 1'b0;
    release_reset();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_sel_cur"}, int'(sel_cur), 0);
    chk({tag, "_busy"},    int'(busy),    0);
    chk({tag, "_done"},    int'(done),    0);
    chk({tag, "_tick"},    int'(tick),    0);
    chk({tag, "_clk_out"}, int'(clk_out), 0);
  endtask

  initial begin
    int unsigned t_first;
    bit          found;

    fork
      monitor_loop();
    join_none

    // Reset state
    #1 rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    release_reset();

    // Up sweep, dwell 1
    expect_ev(1, 1, 32'h11);
    expect_ev(0, 1, 32'h2000);
    expect_ev(0, 2, 32'h3000);
    expect_ev(0, 3, 32'h4000);
    expect_ev(1, 0, 32'h4101);
    expect_ev(2, 1, 32'h4101);
    expect_ev(2, 0, 32'h4102);
    wait_cyc(32'h10);
    pulse_start(1'b0, 4'd1);
    wait_cyc(32'h4110);
    chk("up_dwell1_queue_empty", exp_q.size(), 0);
    chk("up_dwell1_final_sel", int'(sel_cur), 3);

    // Down sweep, dwell 2, with start pulses while busy and in DONE
    do_reset();
    expect_ev(1, 1, 32'h11);
    expect_ev(0, 3, 32'h1000);
    expect_ev(0, 2, 32'h2000);
    expect_ev(0, 1, 32'h3000);
    expect_ev(0, 0, 32'h4000);
    expect_ev(1, 0, 32'h5801);
    expect_ev(2, 1, 32'h5801);
    expect_ev(2, 0, 32'h5802);
    wait_cyc(32'h10);
    pulse_start(1'b1, 4'd2);
    wait_cyc(32'h2005);
    pulse_start(1'b0, 4'd5);
    wait_cyc(32'h5801);
    pulse_start(1'b0, 4'd1);
    wait_cyc(32'h5810);
    chk("down_dwell2_queue_empty", exp_q.size(), 0);
    chk("down_dwell2_final_sel", int'(sel_cur), 0);

    // Dwell 0 behaves as dwell 1; abort at sel 10, start ignored throughout
    do_reset();
    expect_ev(1, 1, 32'h11);
    expect_ev(0, 1, 32'h2000);
    expect_ev(0, 2, 32'h3000);
    expect_ev(1, 0, 32'h3101);
    wait_cyc(32'h10);
    pulse_start(1'b0, 4'd0);
    wait_cyc(32'h2010);
    pulse_start(1'b1, 4'd3);
    wait_cyc(32'h3080);
    pulse_start(1'b1, 4'd3);
    wait_cyc(32'h3100);
    abort = 1'b1;
    @(negedge clk_in);
    abort = 1'b0;
    chk("abort_busy_low", int'(busy), 0);
    wait_cyc(32'h4080);
    chk("abort_queue_empty", exp_q.size(), 0);
    chk("abort_sel_held", int'(sel_cur), 2);

    // Reset mid-RUN
    do_reset();
    expect_ev(1, 1, 32'h11);
    wait_cyc(32'h10);
    pulse_start(1'b0, 4'd1);
    wait_cyc(32'h1080);
    #1 rst_n = 1'b0;
    #1 check_zero_outputs("mid_reset");
    release_reset();
    found = 1'b0;
    t_first = 0;
    while (!found && cyc < 32'h900) begin
      if (tick) begin
        found = 1'b1;
        t_first = cyc;
      end else begin
        @(negedge clk_in);
      end
    end
    chk("post_reset_first_tick_cyc", int'(t_first), 32'h800);
    chk("post_reset_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
